// File: rtl/seg_timer_mux_pkg.sv
// Shared types and helpers for the seg_timer_mux BCD timer / 7-segment scanner.
//   state_e  : FSM state encodings
//   ctl_t    : control bundle {clear, load, stop, start}, MSB first = priority order
//   seg_pat  : BCD digit -> {g,f,e,d,c,b,a} pattern (active high), blank for non-digits
//   bcd_clamp: force a nibble above 9 down to 9
package seg_timer_mux_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_PAUSE = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  typedef struct packed {
    logic clear;
    logic load;
    logic stop;
    logic start;
  } ctl_t;

  localparam logic [6:0] SEG_BLANK = 7'h00;

  function automatic logic [6:0] seg_pat(input logic [3:0] d);
    case (d)
      4'd0:    seg_pat = 7'h3F;
      4'd1:    seg_pat = 7'h06;
      4'd2:    seg_pat = 7'h5B;
      4'd3:    seg_pat = 7'h4F;
      4'd4:    seg_pat = 7'h66;
      4'd5:    seg_pat = 7'h6D;
      4'd6:    seg_pat = 7'h7D;
      4'd7:    seg_pat = 7'h07;
      4'd8:    seg_pat = 7'h7F;
      4'd9:    seg_pat = 7'h6F;
      default: seg_pat = SEG_BLANK;
    endcase
  endfunction

  function automatic logic [3:0] bcd_clamp(input logic [3:0] d);
    return (d > 4'd9) ? 4'd9 : d;
  endfunction

endpackage

// File: rtl/seg_timer_mux_if.sv
// Control / display bundle for seg_timer_mux.
//   master: drives start/stop/clear/load/dir/load_val, observes display and status
//   slave : the timer itself
interface seg_timer_mux_if #(parameter int DIGITS = 4);
  logic                start_i;
  logic                stop_i;
  logic                clear_i;
  logic                load_i;
  logic                dir_i;
  logic [4*DIGITS-1:0] load_val_i;
  logic [7:0]          seg_o;
  logic [DIGITS-1:0]   digit_en_o;
  logic [4*DIGITS-1:0] count_o;
  logic                running_o;
  logic                irq_o;

  modport master (
    output start_i, stop_i, clear_i, load_i, dir_i, load_val_i,
    input  seg_o, digit_en_o, count_o, running_o, irq_o
  );

  modport slave (
    input  start_i, stop_i, clear_i, load_i, dir_i, load_val_i,
    output seg_o, digit_en_o, count_o, running_o, irq_o
  );
endinterface

// File: rtl/seg_timer_mux_bcd_digit.sv
// One BCD digit cell (0..9) with synchronous load and inc/dec enables.
//   clk, rst_n : clock, async active-low reset
//   ld, ld_val : synchronous load (highest priority)
//   inc, dec   : count enables; cy/bw flag that this digit wraps 9->0 / 0->9
//   q          : current digit value
module seg_timer_mux_bcd_digit (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ld,
  input  logic [3:0] ld_val,
  input  logic       inc,
  input  logic       dec,
  output logic [3:0] q,
  output logic       cy,
  output logic       bw
);
  assign cy = inc && (q == 4'd9);
  assign bw = dec && (q == 4'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   q <= 4'd0;
    else if (ld)  q <= ld_val;
    else if (inc) q <= cy ? 4'd0 : q + 4'd1;
    else if (dec) q <= bw ? 4'd9 : q - 4'd1;
  end
endmodule

// File: rtl/seg_timer_mux.sv
// Multi-digit BCD stopwatch / countdown timer with a multiplexed 7-segment driver.
//   wb_clk_i, wb_rst_ni : clock, async active-low reset
//   bus (slave)         : start/stop/clear/load edges, dir, BCD preset in;
//                         seg (dp,g..a), one-hot digit enable, count, running, irq out
module seg_timer_mux
  import seg_timer_mux_pkg::*;
#(
  parameter int DIGITS         = 4,
  parameter int TICK_DIV       = 10000,
  parameter int SCAN_DIV       = 1000,
  parameter bit SEG_ACTIVE_LOW = 1'b0
) (
  input  logic           wb_clk_i,
  input  logic           wb_rst_ni,
  seg_timer_mux_if.slave bus
);
  localparam int PW = $clog2(TICK_DIV);
  localparam int SW = $clog2(SCAN_DIV);
  localparam int IW = $clog2(DIGITS);
  localparam logic [IW-1:0]     IDX_LAST = IW'(DIGITS - 1);
  localparam logic [7:0]        SEG_X    = {8{SEG_ACTIVE_LOW}};
  localparam logic [DIGITS-1:0] EN_X     = {DIGITS{SEG_ACTIVE_LOW}};

  // 2-flop synchroniser plus one history stage for edge detect
  ctl_t [2:0] ctl_pipe;
  ctl_t       rise;
  logic [3:0] rise_v;

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) ctl_pipe <= '0;
    else            ctl_pipe <= {ctl_pipe[1:0],
                                 ctl_t'({bus.clear_i, bus.load_i, bus.stop_i, bus.start_i})};
  end

  assign rise_v = ctl_pipe[1] & ~ctl_pipe[2];
  assign rise   = ctl_t'(rise_v);

  state_e        state_q, state_d;
  logic [PW-1:0] presc_q;
  logic          running, done, enter_run, tick, up_tick, dn_tick, reach_zero;
  logic          cnt_ld, count_zero, count_one, irq_q;

  logic [DIGITS-1:0][3:0] cnt_q, ld_val;
  logic [DIGITS-1:0]      inc_c, dec_c, cy, bw;
  logic                   unused_bw;

  // Any control edge drops a coincident tick
  assign tick       = running && (presc_q == PW'(TICK_DIV - 1)) && !(|rise_v);
  assign count_zero = (cnt_q == '0);
  assign count_one  = (cnt_q == (4*DIGITS)'(1));
  assign up_tick    = tick && !bus.dir_i;
  // Down at zero leaves the count alone; the FSM still moves to DONE
  assign dn_tick    = tick && bus.dir_i && !count_zero;
  assign reach_zero = tick && bus.dir_i && (count_zero || count_one);
  assign cnt_ld     = rise.clear || rise.load;

  assign inc_c     = {cy[DIGITS-2:0], up_tick};
  assign dec_c     = {bw[DIGITS-2:0], dn_tick};
  assign unused_bw = bw[DIGITS-1];

  for (genvar i = 0; i < DIGITS; i++) begin : g_dig
    assign ld_val[i] = rise.clear ? 4'd0 : bcd_clamp(bus.load_val_i[4*i +: 4]);
    seg_timer_mux_bcd_digit u_dig (
      .clk    (wb_clk_i),
      .rst_n  (wb_rst_ni),
      .ld     (cnt_ld),
      .ld_val (ld_val[i]),
      .inc    (inc_c[i]),
      .dec    (dec_c[i]),
      .q      (cnt_q[i]),
      .cy     (cy[i]),
      .bw     (bw[i])
    );
  end

  // FSM: state register
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) state_q <= S_IDLE;
    else            state_q <= state_d;
  end

  // FSM: next state, priority clear > load > stop > start > tick
  always_comb begin
    state_d = state_q;
    if (rise.clear || rise.load) begin
      state_d = S_IDLE;
    end else if (rise.stop) begin
      if (state_q == S_RUN) state_d = S_PAUSE;
    end else if (rise.start) begin
      if (state_q == S_IDLE || state_q == S_PAUSE || (state_q == S_DONE && !bus.dir_i))
        state_d = S_RUN;
    end else if (reach_zero) begin
      state_d = S_DONE;
    end
  end

  // FSM: outputs
  always_comb begin
    running   = (state_q == S_RUN);
    done      = (state_q == S_DONE);
    enter_run = (state_d == S_RUN) && (state_q != S_RUN);
  end

  // Prescaler only moves in RUN; held in PAUSE, restarted on every RUN entry
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni)                 presc_q <= '0;
    else if (enter_run || tick)     presc_q <= '0;
    else if (running && !(|rise_v)) presc_q <= presc_q + PW'(1);
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) irq_q <= 1'b0;
    else            irq_q <= (up_tick && cy[DIGITS-1]) || reach_zero;
  end

  // Free-running scan; frame_q counts full display frames for the DONE blink
  logic [SW-1:0]     scan_q;
  logic [IW-1:0]     idx_q;
  logic [5:0]        frame_q;
  logic [7:0]        seg_raw, seg_q;
  logic [DIGITS-1:0] en_q;

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      scan_q  <= '0;
      idx_q   <= '0;
      frame_q <= '0;
    end else if (scan_q == SW'(SCAN_DIV - 1)) begin
      scan_q <= '0;
      if (idx_q == IDX_LAST) begin
        idx_q   <= '0;
        frame_q <= frame_q + 6'd1;
      end else begin
        idx_q <= idx_q + IW'(1);
      end
    end else begin
      scan_q <= scan_q + SW'(1);
    end
  end

  assign seg_raw = {running && (idx_q == '0),
                    (done && frame_q[5]) ? SEG_BLANK : seg_pat(cnt_q[idx_q])};

  // Segments and enable register on the same edge so a digit never shows a neighbour's pattern
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      seg_q <= {1'b0, seg_pat(4'd0)} ^ SEG_X;
      en_q  <= DIGITS'(1) ^ EN_X;
    end else begin
      seg_q <= seg_raw ^ SEG_X;
      en_q  <= (DIGITS'(1) << idx_q) ^ EN_X;
    end
  end

  assign bus.seg_o      = seg_q;
  assign bus.digit_en_o = en_q;
  assign bus.count_o    = cnt_q;
  assign bus.running_o  = running;
  assign bus.irq_o      = irq_q;
endmodule
